pc_fetch_unit: RTL and testbench

//  Parametrised program-counter and fetch sequencer; successor to the PC logic inside the datapath.

---
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: fetches one instruction over a req/ready handshake,
// holds it for execute, then advances the PC (sequential, Bcond, Jcond or JAL with link).
module pc_fetch_unit #(
   parameter int WIDTH     = 16,
   parameter int DISP_BITS = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [WIDTH-1:0]     imem_addr,
   input  logic                 imem_ready,
   input  logic [WIDTH-1:0]     imem_rdata,
   output logic [WIDTH-1:0]     instr,
   output logic                 instr_valid,
   input  logic                 exec_done,
   input  logic                 br_valid,
   input  logic [1:0]           br_kind,
   input  logic [3:0]           cond,
   input  logic [4:0]           flags,
   input  logic [DISP_BITS-1:0] disp,
   input  logic [WIDTH-1:0]     target,
   output logic [WIDTH-1:0]     pc,
   output logic [WIDTH-1:0]     link,
   output logic                 link_we,
   output logic [CNT_WIDTH-1:0] retire_count,
   output logic                 dbgState
);

   // Handshakes: a fetch completes in any cycle where imem_req && imem_ready; an instruction
   // retires in any cycle where instr_valid && exec_done. Neither side may retract mid-wait.
   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} stateT;

   localparam logic [1:0] KIND_BCOND = 2'b00;
   localparam logic [1:0] KIND_JCOND = 2'b01;
   localparam logic [1:0] KIND_JAL   = 2'b10;

   stateT                state, stateNext;
   logic [WIDTH-1:0]     pcNext, pcPlusOne, dispExt;
   logic [CNT_WIDTH-1:0] retireCount;
   logic                 instrLoad, retire, takeJal, condOk;

   function automatic logic condTrue(input logic [3:0] c, input logic [4:0] f);
      logic fc, fl, ff, fz, fn;
      logic result;
      {fc, fl, ff, fz, fn} = f;
      case (c)
         4'h0: result = fz;
         4'h1: result = !fz;
         4'h2: result = fc;
         4'h3: result = !fc;
         4'h4: result = fl;
         4'h5: result = !fl;
         4'h6: result = fn;
         4'h7: result = !fn;
         4'h8: result = ff;
         4'h9: result = !ff;
         4'hA: result = !fl && !fz;
         4'hB: result = fl || fz;
         4'hC: result = !fn && !fz;
         4'hD: result = fn || fz;
         4'hE: result = 1'b1;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

   assign pcPlusOne    = pc + {{(WIDTH-1){1'b0}}, 1'b1};
   assign dispExt      = {{(WIDTH-DISP_BITS){disp[DISP_BITS-1]}}, disp};
   assign condOk       = condTrue(cond, flags);
   assign imem_addr    = pc;
   assign retire_count = retireCount;
   assign dbgState     = state;

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      instrLoad   = 1'b0;
      retire      = 1'b0;
      takeJal     = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               instrLoad = 1'b1;
               stateNext = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (exec_done) begin
               retire    = 1'b1;
               stateNext = FETCH;
               pcNext    = pcPlusOne;
               // Reserved kind 11 falls through as a plain sequential advance.
               if (br_valid) begin
                  case (br_kind)
                     KIND_BCOND: if (condOk) pcNext = pc + dispExt;
                     KIND_JCOND: if (condOk) pcNext = target;
                     KIND_JAL: begin
                        pcNext  = target;
                        takeJal = 1'b1;
                     end
                     default: pcNext = pcPlusOne;
                  endcase
               end
            end
         end
         default: stateNext = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= '0;
         retireCount <= '0;
         link        <= '0;
         link_we     <= 1'b0;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         link_we <= takeJal;
         if (instrLoad) instr <= imem_rdata;
         if (retire) retireCount <= retireCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         if (takeJal) link <= pcPlusOne;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branches, JAL link, stalls, wrap and reset.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        exec_done;
   logic        br_valid;
   logic [1:0]  br_kind;
   logic [3:0]  cond;
   logic [4:0]  flags;
   logic [7:0]  disp;
   logic [15:0] target;
   logic [15:0] pc;
   logic [15:0] link;
   logic        link_we;
   logic [2:0]  retire_count;
   logic        dbgState;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  expCount = 3'd0;

   // Narrow counter so the wrap from 7 to 0 happens within the directed sequence.
   pc_fetch_unit #(.WIDTH(16), .DISP_BITS(8), .RESET_PC(16'h0000), .CNT_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .exec_done(exec_done), .br_valid(br_valid),
      .br_kind(br_kind), .cond(cond), .flags(flags), .disp(disp), .target(target),
      .pc(pc), .link(link), .link_we(link_we), .retire_count(retire_count),
      .dbgState(dbgState)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in FETCH; returns at the negedge just after the instruction retires.
   task automatic step(input string tag, input logic [15:0] expAddr, input logic [15:0] rdata,
                       input logic brV, input logic [1:0] kind, input logic [3:0] cnd,
                       input logic [4:0] flg, input logic [7:0] dsp, input logic [15:0] tgt,
                       input logic [15:0] expNextPc);
      check({tag, "_req"}, imem_req, 1);
      check({tag, "_addr"}, imem_addr, expAddr);
      check({tag, "_ivalid_fetch"}, instr_valid, 0);
      imem_ready = 1'b1;
      imem_rdata = rdata;
      @(posedge clk); @(negedge clk);
      imem_ready = 1'b0;
      check({tag, "_instr"}, instr, rdata);
      check({tag, "_ivalid_exec"}, instr_valid, 1);
      check({tag, "_req_exec"}, imem_req, 0);
      check({tag, "_linkwe_exec"}, link_we, 0);
      exec_done = 1'b1;
      br_valid  = brV;
      br_kind   = kind;
      cond      = cnd;
      flags     = flg;
      disp      = dsp;
      target    = tgt;
      @(posedge clk); @(negedge clk);
      exec_done = 1'b0;
      br_valid  = 1'b0;
      expCount  = expCount + 3'd1;
      check({tag, "_pc"}, pc, expNextPc);
      check({tag, "_count"}, retire_count, expCount);
      check({tag, "_linkwe"}, link_we, (brV && kind == 2'b10) ? 1 : 0);
   endtask

   initial begin
      reset = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0; exec_done = 1'b0;
      br_valid = 1'b0; br_kind = 2'b00; cond = 4'h0; flags = 5'h0; disp = 8'h0; target = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pc", pc, 16'h0000);
      check("rst_instr", instr, 16'h0000);
      check("rst_count", retire_count, 0);
      check("rst_req", imem_req, 1);
      check("rst_ivalid", instr_valid, 0);
      check("rst_linkwe", link_we, 0);
      check("rst_state", dbgState, 0);
      reset = 1'b1;

      // Sequential fetch from reset
      step("seq0", 16'h0000, 16'h1111, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0001);
      step("seq1", 16'h0001, 16'h2222, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0002);
      step("seq2", 16'h0002, 16'h3333, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0003);
      step("seq3", 16'h0003, 16'h4444, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0004);
      check("seq_count4", retire_count, 3'd4);

      // Bcond EQ, taken (Z=1, disp -4) and not taken (Z=0)
      step("j10", 16'h0004, 16'h5000, 1, 2'b01, 4'hE, 5'h00, 8'h00, 16'h0010, 16'h0010);
      step("beq_t", 16'h0010, 16'h5001, 1, 2'b00, 4'h0, 5'b00010, 8'hFC, 16'h0000, 16'h000C);
      step("j10b", 16'h000C, 16'h5002, 1, 2'b01, 4'hE, 5'h00, 8'h00, 16'h0010, 16'h0010);
      step("beq_n", 16'h0010, 16'h5003, 1, 2'b00, 4'h0, 5'b00000, 8'hFC, 16'h0000, 16'h0011);

      // JAL ignores cond; link_we high for exactly the one cycle after retire
      step("j20", 16'h0011, 16'h6000, 1, 2'b01, 4'hE, 5'h00, 8'h00, 16'h0020, 16'h0020);
      step("jal", 16'h0020, 16'h6001, 1, 2'b10, 4'hF, 5'h00, 8'h00, 16'h0100, 16'h0100);
      check("jal_link", link, 16'h0021);
      step("post_jal", 16'h0100, 16'h6002, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0101);
      check("link_hold", link, 16'h0021);

      // Fetch stall: exec_done pulses while fetching must not advance anything
      for (int i = 0; i < 3; i++) begin
         exec_done = 1'b1;
         br_valid  = 1'b1;
         br_kind   = 2'b01;
         cond      = 4'hE;
         target    = 16'h0BAD;
         @(posedge clk); @(negedge clk);
         check("stall_req", imem_req, 1);
         check("stall_addr", imem_addr, 16'h0101);
         check("stall_ivalid", instr_valid, 0);
      end
      exec_done = 1'b0;
      br_valid  = 1'b0;
      check("stall_count", retire_count, expCount);
      step("after_stall", 16'h0101, 16'h7000, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0102);

      // Reserved kind acts as sequential; LO taken, HS not taken
      step("rsvd", 16'h0102, 16'h7001, 1, 2'b11, 4'hE, 5'h00, 8'h00, 16'h0500, 16'h0103);
      step("blo_t", 16'h0103, 16'h7002, 1, 2'b00, 4'hA, 5'b00000, 8'h02, 16'h0000, 16'h0105);
      step("bhs_n", 16'h0105, 16'h7003, 1, 2'b00, 4'hB, 5'b00000, 8'h05, 16'h0000, 16'h0106);
      step("bgt_t", 16'h0106, 16'h7004, 1, 2'b00, 4'h6, 5'b00001, 8'h10, 16'h0000, 16'h0116);

      // PC wrap at the top of the address space; never vs unconditional Jcond
      step("jffff", 16'h0116, 16'h8000, 1, 2'b01, 4'hE, 5'h00, 8'h00, 16'hFFFF, 16'hFFFF);
      step("jnever", 16'hFFFF, 16'h8001, 1, 2'b01, 4'hF, 5'h1F, 8'h00, 16'h0055, 16'h0000);
      step("juc", 16'h0000, 16'h8002, 1, 2'b01, 4'hE, 5'h00, 8'h00, 16'h0055, 16'h0055);

      // Most-negative and most-positive displacements, with wrap through 0
      step("bneg", 16'h0055, 16'h8003, 1, 2'b00, 4'hE, 5'h00, 8'h80, 16'h0000, 16'hFFD5);
      step("bpos", 16'hFFD5, 16'h8004, 1, 2'b00, 4'hE, 5'h00, 8'h7F, 16'h0000, 16'h0054);

      // Reset asserted mid-execute beats a concurrent exec_done
      imem_ready = 1'b1;
      imem_rdata = 16'h9000;
      @(posedge clk); @(negedge clk);
      imem_ready = 1'b0;
      check("pre_rst_ivalid", instr_valid, 1);
      reset     = 1'b0;
      exec_done = 1'b1;
      br_valid  = 1'b1;
      br_kind   = 2'b10;
      target    = 16'h0777;
      @(posedge clk); @(negedge clk);
      exec_done = 1'b0;
      br_valid  = 1'b0;
      check("mid_rst_pc", pc, 16'h0000);
      check("mid_rst_ivalid", instr_valid, 0);
      check("mid_rst_count", retire_count, 0);
      check("mid_rst_req", imem_req, 1);
      check("mid_rst_instr", instr, 16'h0000);
      check("mid_rst_linkwe", link_we, 0);
      reset    = 1'b1;
      expCount = 3'd0;
      step("post_rst", 16'h0000, 16'hA000, 0, 2'b00, 4'h0, 5'h00, 8'h00, 16'h0000, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
